// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit add/sub, CHUNK bits resolved per stage; `define ADD_OVF_FLAG_EN adds out_ovf
module pipelined_carry_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef ADD_OVF_FLAG_EN
    ,
    output logic             out_ovf
`endif
);
    localparam int CH = CHUNK < 1 ? 1 : CHUNK;
    localparam int STAGES = WIDTH / CH;

    if (CHUNK < 1 || WIDTH < 2 || WIDTH % CH != 0) begin : g_bad_params
        $error("pipelined_carry_adder: WIDTH must be >= 2 and a multiple of CHUNK >= 1");
    end

    logic en;
    logic iv_q, iv_d, ic_q, ic_d;
    logic [WIDTH-1:0] ia_q, ia_d, ib_q, ib_d;

    // whole pipeline advances unless a result is waiting on the consumer
    always_comb begin
        en = !out_valid || out_ready;
        in_ready = en;
    end

    // effective operands: subtract is A + ~B + 1, cin ignored
    always_comb begin
        iv_d = in_valid;
        ia_d = in_a;
        ib_d = in_sub ? ~in_b : in_b;
        ic_d = in_sub | in_cin;
    end

    // input register holding the operand set of the accepted operation
    always_ff @(posedge clk) begin
        if (rst) begin
            iv_q <= 1'b0;
            ic_q <= 1'b0;
            ia_q <= '0;
            ib_q <= '0;
        end else if (en) begin
            iv_q <= iv_d;
            ic_q <= ic_d;
            ia_q <= ia_d;
            ib_q <= ib_d;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * CH;
        localparam int REM = WIDTH - LO;
        logic [REM-1:0] a_i, b_i;
        logic c_i;
        logic [CH:0] add;
        logic v_q, v_d, c_q, c_d;
        logic [LO+CH-1:0] s_q, s_d;
        if (k == 0) begin : g_first
            // lowest slice adds the registered operands with c0
            always_comb begin
                a_i = ia_q;
                b_i = ib_q;
                c_i = ic_q;
                v_d = iv_q;
                add = {1'b0, a_i[CH-1:0]} + {1'b0, b_i[CH-1:0]} + {{CH{1'b0}}, c_i};
                s_d = add[CH-1:0];
                c_d = add[CH];
            end
        end else begin : g_next
            // upper slice adds skewed operands with the previous stage's carry, appending to the finished low sum
            always_comb begin
                a_i = g_st[k-1].g_ops.a_q;
                b_i = g_st[k-1].g_ops.b_q;
                c_i = g_st[k-1].c_q;
                v_d = g_st[k-1].v_q;
                add = {1'b0, a_i[CH-1:0]} + {1'b0, b_i[CH-1:0]} + {{CH{1'b0}}, c_i};
                s_d = {add[CH-1:0], g_st[k-1].s_q};
                c_d = add[CH];
            end
        end
        // stage registers: valid bit, carry out and the sum bits resolved so far
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_d;
                c_q <= c_d;
                s_q <= s_d;
            end
        end
        if (k < STAGES - 1) begin : g_ops
            logic [REM-CH-1:0] a_q, a_d, b_q, b_d;
            // operand slices not yet added move ahead to the next stage
            always_comb begin
                a_d = a_i[REM-1:CH];
                b_d = b_i[REM-1:CH];
            end
            // skew registers for the pending operand slices
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign out_sum   = g_st[STAGES-1].s_q;
    assign out_cout  = g_st[STAGES-1].c_q;

`ifdef ADD_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    // signed overflow: carry into the MSB differs from the carry out of it
    always_comb begin
        ovf_d = g_st[STAGES-1].a_i[CH-1] ^ g_st[STAGES-1].b_i[CH-1]
              ^ g_st[STAGES-1].add[CH-1] ^ g_st[STAGES-1].add[CH];
    end

    // overflow flag registered alongside the top sum slice
    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else if (en) ovf_q <= ovf_d;
    end

    assign out_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// tb_pipelined_carry_adder: directed checks of the pipelined adder with WIDTH=16, CHUNK=4
module tb_pipelined_carry_adder;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout;
    logic [W-1:0] in_a, in_b, out_sum;
`ifdef ADD_OVF_FLAG_EN
    logic out_ovf;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipelined_carry_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .in_cin(in_cin),
        .in_sub(in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_cout(out_cout)
`ifdef ADD_OVF_FLAG_EN
        ,
        .out_ovf(out_ovf)
`endif
    );

    // send one operation and wait (bounded) for its result; caller is at posedge+1
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub,
                          output logic [W-1:0] s, output logic co, output int lat);
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_sub = sub;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        s = out_sum;
        co = out_cout;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        in_sub = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
        tests++; if (out_sum !== 16'h0000) begin fails++; $display("FAIL reset_sum got %h want 0000", out_sum); end
        tests++; if (out_cout !== 1'b0) begin fails++; $display("FAIL reset_cout got %b want 0", out_cout); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef ADD_OVF_FLAG_EN
        tests++; if (out_ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        logic [W-1:0] s;
        logic co;
        int lat;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, co, lat);
        tests++; if (s !== 16'h0000) begin fails++; $display("FAIL add_wrap_sum got %h want 0000", s); end
        tests++; if (co !== 1'b1) begin fails++; $display("FAIL add_wrap_cout got %b want 1", co); end
        tests++; if (lat != 4) begin fails++; $display("FAIL add_latency got %0d want 4", lat); end
        run_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, s, co, lat);
        tests++; if (s !== 16'h0001) begin fails++; $display("FAIL add_cin_sum got %h want 0001", s); end
        tests++; if (co !== 1'b1) begin fails++; $display("FAIL add_cin_cout got %b want 1", co); end
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, lat);
        tests++; if (s !== 16'h8000 || co !== 1'b0) begin fails++; $display("FAIL add_7fff got %h/%b want 8000/0", s, co); end
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, s, co, lat);
        tests++; if (s !== 16'h1000 || co !== 1'b0) begin fails++; $display("FAIL add_ripple got %h/%b want 1000/0", s, co); end
    endtask

    task automatic test_sub();
        logic [W-1:0] s;
        logic co;
        int lat;
        run_op(16'h1234, 16'h1235, 1'b1, 1'b1, s, co, lat);
        tests++; if (s !== 16'hFFFF) begin fails++; $display("FAIL sub_borrow_sum got %h want ffff", s); end
        tests++; if (co !== 1'b0) begin fails++; $display("FAIL sub_borrow_cout got %b want 0", co); end
        tests++; if (lat != 4) begin fails++; $display("FAIL sub_latency got %0d want 4", lat); end
        run_op(16'h0005, 16'h0003, 1'b0, 1'b1, s, co, lat);
        tests++; if (s !== 16'h0002) begin fails++; $display("FAIL sub_sum got %h want 0002", s); end
        tests++; if (co !== 1'b1) begin fails++; $display("FAIL sub_cout got %b want 1", co); end
    endtask

`ifdef ADD_OVF_FLAG_EN
    task automatic test_ovf();
        logic [W-1:0] s;
        logic co;
        int lat;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, co, lat);
        tests++; if (s !== 16'h8000 || out_ovf !== 1'b1) begin fails++; $display("FAIL ovf_add got %h/%b want 8000/1", s, out_ovf); end
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, s, co, lat);
        tests++; if (s !== 16'h7FFF || out_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sub got %h/%b want 7fff/1", s, out_ovf); end
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, s, co, lat);
        tests++; if (s !== 16'h0007 || out_ovf !== 1'b0) begin fails++; $display("FAIL ovf_none got %h/%b want 0007/0", s, out_ovf); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [W-1:0] exp [8] = '{16'h0101, 16'h1212, 16'h2323, 16'h3434,
                                  16'h4545, 16'h5656, 16'h6767, 16'h7878};
        int got = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            in_valid = t < 8;
            in_a = 16'(t) * 16'h1111;
            in_b = 16'h0101;
            in_cin = 1'b0;
            in_sub = 1'b0;
            @(posedge clk);
            #1;
            if (out_valid) begin
                tests++;
                if (got >= 8) begin
                    fails++; $display("FAIL stream_extra got %h at cycle %0d want none", out_sum, t);
                end else if (out_sum !== exp[got] || out_cout !== 1'b0 || t != 4 + got) begin
                    fails++; $display("FAIL stream_%0d got %h/%b at cycle %0d want %h/0 at cycle %0d", got, out_sum, out_cout, t, exp[got], 4 + got);
                end
                got++;
            end
        end
        in_valid = 1'b0;
        tests++; if (got != 8) begin fails++; $display("FAIL stream_count got %0d want 8", got); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp [8] = '{16'h1200, 16'h1201, 16'h1202, 16'h1203,
                                  16'h1204, 16'h1205, 16'h1206, 16'h1207};
        int issued = 0;
        int got = 0;
        int stalls = 0;
        int extra = 0;
        for (int t = 0; t < 40 && got < 8; t++) begin
            out_ready = !(t >= 6 && t <= 8);
            in_valid = issued < 8;
            in_a = 16'h1000 + 16'(issued);
            in_b = 16'h0200;
            in_cin = 1'b0;
            in_sub = 1'b0;
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cycle %0d got %b want 0", t, in_ready); end
                tests++; if (out_sum !== exp[got]) begin fails++; $display("FAIL bp_hold cycle %0d got %h want %h", t, out_sum, exp[got]); end
            end
            if (out_valid && out_ready) begin
                tests++; if (out_sum !== exp[got]) begin fails++; $display("FAIL bp_order_%0d got %h want %h", got, out_sum, exp[got]); end
                got++;
            end
            if (in_valid && in_ready) issued++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tests++; if (got != 8) begin fails++; $display("FAIL bp_count got %0d want 8", got); end
        tests++; if (stalls != 3) begin fails++; $display("FAIL bp_stalls got %0d want 3", stalls); end
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) extra++;
        end
        tests++; if (extra != 0) begin fails++; $display("FAIL bp_duplicates got %0d want 0", extra); end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = 16'h4000 + 16'(i);
            in_b = 16'h0001;
            in_cin = 1'b0;
            in_sub = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        tests++; if (out_sum !== 16'h0000) begin fails++; $display("FAIL midrst_sum got %h want 0000", out_sum); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL midrst_ghosts got %0d want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
`ifdef ADD_OVF_FLAG_EN
        test_ovf();
`endif
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
